// File: rtl/cvxif_cplx_copro.sv
`default_nettype none
// ============================================================================
// cvxif_cplx_copro : pipelined complex add/conj/sub/mul coprocessor on CVXIF
// Revision 1.0
// ============================================================================
module cvxif_cplx_copro #(
  parameter int XLEN  = 32,
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_req_instr,
  input  logic [ID_W-1:0] issue_req_id,
  output logic            issue_resp_accept,
  output logic            issue_resp_writeback,
  output logic [1:0]      issue_resp_register_read,
  input  logic            register_valid,
  output logic            register_ready,
  input  logic [XLEN-1:0] register_rs0,
  input  logic [XLEN-1:0] register_rs1,
  input  logic [1:0]      register_rs_valid,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [ID_W-1:0] result_id,
  output logic [XLEN-1:0] result_data
);

  localparam int         W       = XLEN / 2;
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [6:0] C_OPC   = 7'b1111011;
  localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

  // ---------------------------------------------------------------- decode
  logic [2:0] w_f3;
  logic       w_match;
  logic       w_accept;
  logic       w_unused_instr;

  assign w_f3           = issue_req_instr[14:12];
  assign w_match        = rst && (issue_req_instr[6:0] == C_OPC) &&
                          (issue_req_instr[31:25] == 7'd0) && !w_f3[2];
  assign w_unused_instr = ^{issue_req_instr[24:15], issue_req_instr[11:7]};

  assign issue_resp_accept        = w_match;
  assign issue_resp_writeback     = w_match;
  assign issue_resp_register_read = !w_match ? 2'b00 :
                                    (w_f3[1:0] == 2'b01) ? 2'b01 : 2'b11;

  // ---------------------------------------------------------------- credits
  logic [AW:0] occ_q, occ_d;
  logic        w_pop;

  assign issue_ready = rst && (occ_q != C_DEPTH);
  assign w_accept    = issue_valid && issue_ready && w_match;

  always_comb begin
    occ_d = occ_q;
    case ({w_accept, w_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------- pending queue
  logic [1:0]      pq_op_q [DEPTH];
  logic [ID_W-1:0] pq_id_q [DEPTH];
  logic [AW-1:0]   pq_wp_q, pq_rp_q;
  logic [AW:0]     pq_cnt_q, pq_cnt_d;
  logic [1:0]      w_head_op;
  logic [ID_W-1:0] w_head_id;
  logic [1:0]      w_mask;
  logic            w_op_hs;

  assign register_ready = (pq_cnt_q != '0);
  assign w_head_op      = pq_op_q[pq_rp_q];
  assign w_head_id      = pq_id_q[pq_rp_q];
  assign w_mask         = (w_head_op == 2'b01) ? 2'b01 : 2'b11;
  assign w_op_hs        = register_valid && register_ready &&
                          ((register_rs_valid & w_mask) == w_mask);

  always_comb begin
    pq_cnt_d = pq_cnt_q;
    case ({w_accept, w_op_hs})
      2'b10:   pq_cnt_d = pq_cnt_q + 1'b1;
      2'b01:   pq_cnt_d = pq_cnt_q - 1'b1;
      default: pq_cnt_d = pq_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      pq_op_q[pq_wp_q] <= w_f3[1:0];
      pq_id_q[pq_wp_q] <= issue_req_id;
    end
  end

  // ------------------------------------------------------------ arithmetic
  logic [W-1:0]    w_ar, w_ai, w_br, w_bi, w_re, w_im;
  logic [XLEN-1:0] w_res;

  assign w_ar  = register_rs0[W-1:0];
  assign w_ai  = register_rs0[XLEN-1:W];
  assign w_br  = register_rs1[W-1:0];
  assign w_bi  = register_rs1[XLEN-1:W];
  assign w_res = {w_im, w_re};

  // Low W bits of a product are sign-agnostic, so unsigned multiply suffices.
  always_comb begin
    w_re = '0;
    w_im = '0;
    case (w_head_op)
      2'b00: begin w_re = w_ar + w_br;               w_im = w_ai + w_bi;               end
      2'b01: begin w_re = w_ar;                      w_im = '0 - w_ai;                 end
      2'b10: begin w_re = w_ar - w_br;               w_im = w_ai - w_bi;               end
      default: begin w_re = w_ar * w_br - w_ai * w_bi; w_im = w_ar * w_bi + w_ai * w_br; end
    endcase
  end

  // -------------------------------------------------------------- pipeline
  logic            w_push;
  logic [ID_W-1:0] w_push_id;
  logic [XLEN-1:0] w_push_data;

  generate
    if (LAT == 1) begin : g_pipe_direct
      assign w_push      = w_op_hs;
      assign w_push_id   = w_head_id;
      assign w_push_data = w_res;
    end else begin : g_pipe_regs
      // The FIFO write is the final stage, so only LAT-1 registers sit in front of it.
      logic            pv_q [LAT-1];
      logic [ID_W-1:0] pid_q [LAT-1];
      logic [XLEN-1:0] pd_q [LAT-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LAT-1; i++) begin
            pv_q[i]  <= 1'b0;
            pid_q[i] <= '0;
            pd_q[i]  <= '0;
          end
        end else begin
          pv_q[0]  <= w_op_hs;
          pid_q[0] <= w_head_id;
          pd_q[0]  <= w_res;
          for (int i = 1; i < LAT-1; i++) begin
            pv_q[i]  <= pv_q[i-1];
            pid_q[i] <= pid_q[i-1];
            pd_q[i]  <= pd_q[i-1];
          end
        end
      end

      assign w_push      = pv_q[LAT-2];
      assign w_push_id   = pid_q[LAT-2];
      assign w_push_data = pd_q[LAT-2];
    end
  endgenerate

  // ----------------------------------------------------------- result FIFO
  logic [ID_W-1:0] rf_id_q [DEPTH];
  logic [XLEN-1:0] rf_dat_q [DEPTH];
  logic [AW-1:0]   rf_wp_q, rf_rp_q;
  logic [AW:0]     rf_cnt_q, rf_cnt_d;

  assign result_valid = (rf_cnt_q != '0);
  assign result_id    = result_valid ? rf_id_q[rf_rp_q]  : '0;
  assign result_data  = result_valid ? rf_dat_q[rf_rp_q] : '0;
  assign w_pop        = result_valid && result_ready;

  always_comb begin
    rf_cnt_d = rf_cnt_q;
    case ({w_push, w_pop})
      2'b10:   rf_cnt_d = rf_cnt_q + 1'b1;
      2'b01:   rf_cnt_d = rf_cnt_q - 1'b1;
      default: rf_cnt_d = rf_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      rf_id_q[rf_wp_q]  <= w_push_id;
      rf_dat_q[rf_wp_q] <= w_push_data;
    end
  end

  // ------------------------------------------------------- control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q    <= '0;
      pq_wp_q  <= '0;
      pq_rp_q  <= '0;
      pq_cnt_q <= '0;
      rf_wp_q  <= '0;
      rf_rp_q  <= '0;
      rf_cnt_q <= '0;
    end else begin
      occ_q    <= occ_d;
      pq_cnt_q <= pq_cnt_d;
      rf_cnt_q <= rf_cnt_d;
      if (w_accept) pq_wp_q <= pq_wp_q + 1'b1;
      if (w_op_hs)  pq_rp_q <= pq_rp_q + 1'b1;
      if (w_push)   rf_wp_q <= rf_wp_q + 1'b1;
      if (w_pop)    rf_rp_q <= rf_rp_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cvxif_cplx_copro.sv
`default_nettype none
// ============================================================================
// tb_cvxif_cplx_copro : directed bench with a transaction-level reference model
// Revision 1.0
// ============================================================================
module tb_cvxif_cplx_copro;

  localparam int XLEN  = 32;
  localparam int ID_W  = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [31:0]     issue_req_instr = '0;
  logic [ID_W-1:0] issue_req_id = '0;
  logic            issue_resp_accept;
  logic            issue_resp_writeback;
  logic [1:0]      issue_resp_register_read;
  logic            register_valid = 1'b0;
  logic            register_ready;
  logic [XLEN-1:0] register_rs0 = '0;
  logic [XLEN-1:0] register_rs1 = '0;
  logic [1:0]      register_rs_valid = '0;
  logic            result_valid;
  logic            result_ready = 1'b1;
  logic [ID_W-1:0] result_id;
  logic [XLEN-1:0] result_data;

  cvxif_cplx_copro #(.XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_req_instr(issue_req_instr), .issue_req_id(issue_req_id),
    .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
    .issue_resp_register_read(issue_resp_register_read),
    .register_valid(register_valid), .register_ready(register_ready),
    .register_rs0(register_rs0), .register_rs1(register_rs1),
    .register_rs_valid(register_rs_valid),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_data(result_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b1111011};
  endfunction

  // Reference arithmetic on signed integers, truncated to 16 bits per half.
  function automatic logic [31:0] cplx(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    int ar, ai, br, bi, re, im;
    ar = $signed(a[15:0]); ai = $signed(a[31:16]);
    br = $signed(b[15:0]); bi = $signed(b[31:16]);
    case (op)
      2'd0:    begin re = ar + br; im = ai + bi; end
      2'd1:    begin re = ar;      im = -ai;     end
      2'd2:    begin re = ar - br; im = ai - bi; end
      default: begin re = ar*br - ai*bi; im = ar*bi + ai*br; end
    endcase
    return {im[15:0], re[15:0]};
  endfunction

  // ------------------------------------------------------ reference model
  typedef struct { logic [1:0] op; logic [ID_W-1:0] id; } pend_t;
  typedef struct { logic [ID_W-1:0] id; logic [31:0] data; int due; } res_t;

  pend_t m_pend[$];
  res_t  m_res[$];
  int    m_occ = 0;
  int    cyc   = 0;
  logic  m_rv, m_match, m_acc, m_ohs, m_pop;
  logic [1:0] m_rr, m_mask;
  pend_t m_p;
  res_t  m_r;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_issue_ready", issue_ready, 0);
      chk("rst_accept", issue_resp_accept, 0);
      chk("rst_writeback", issue_resp_writeback, 0);
      chk("rst_register_read", issue_resp_register_read, 0);
      chk("rst_register_ready", register_ready, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_id", result_id, 0);
      chk("rst_result_data", result_data, 0);
      m_pend.delete();
      m_res.delete();
      m_occ = 0;
    end else begin
      m_rv = (m_res.size() > 0) && (m_res[0].due <= cyc);
      chk("issue_ready", issue_ready, m_occ < DEPTH);
      chk("register_ready", register_ready, m_pend.size() > 0);
      chk("result_valid", result_valid, m_rv);
      if (m_rv) begin
        chk("result_id", result_id, m_res[0].id);
        chk("result_data", result_data, m_res[0].data);
      end
      m_match = issue_req_instr[6:0] == 7'b1111011 && issue_req_instr[31:25] == 0 &&
                issue_req_instr[14:12] < 4;
      m_rr = !m_match ? 2'b00 : (issue_req_instr[14:12] == 1) ? 2'b01 : 2'b11;
      if (issue_valid) begin
        chk("accept", issue_resp_accept, m_match);
        chk("writeback", issue_resp_writeback, m_match);
        chk("register_read", issue_resp_register_read, m_rr);
      end
      m_acc  = issue_valid && (m_occ < DEPTH) && m_match;
      m_mask = (m_pend.size() > 0 && m_pend[0].op == 1) ? 2'b01 : 2'b11;
      m_ohs  = register_valid && (m_pend.size() > 0) &&
               ((register_rs_valid & m_mask) == m_mask);
      m_pop  = m_rv && result_ready;
      if (m_pop) void'(m_res.pop_front());
      if (m_ohs) begin
        m_p = m_pend.pop_front();
        m_r.id = m_p.id;
        m_r.data = cplx(m_p.op, register_rs0, register_rs1);
        m_r.due = cyc + LAT;
        m_res.push_back(m_r);
      end
      if (m_acc) begin
        m_p.op = issue_req_instr[13:12];
        m_p.id = issue_req_id;
        m_pend.push_back(m_p);
      end
      m_occ = m_occ + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
    end
    cyc++;
  end

  // ---------------------------------------------------------------- drivers
  task automatic do_issue(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [ID_W-1:0] id, output logic acc, output logic [1:0] rr);
    int n = 0;
    issue_valid = 1'b1;
    issue_req_instr = mk_instr(f7, f3);
    issue_req_id = id;
    @(negedge clk);
    while (!issue_ready && n < 50) begin @(negedge clk); n++; end
    if (!issue_ready) chk("issue_timeout", 0, 1);
    acc = issue_resp_accept;
    rr  = issue_resp_register_read;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic do_operands(input logic [31:0] a, input logic [31:0] b, input logic [1:0] v);
    int n = 0;
    register_valid = 1'b1;
    register_rs0 = a;
    register_rs1 = b;
    register_rs_valid = v;
    @(negedge clk);
    while (!register_ready && n < 50) begin @(negedge clk); n++; end
    if (!register_ready) chk("operand_timeout", 0, 1);
    @(posedge clk); #1;
    register_valid = 1'b0;
    register_rs_valid = 2'b00;
  endtask

  task automatic wait_result(input string nm, input logic [ID_W-1:0] id,
                             input logic [31:0] data, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!result_valid && n < 30);
    chk({nm, "_valid"}, result_valid, 1);
    chk({nm, "_id"}, result_id, id);
    chk({nm, "_data"}, result_data, data);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic       acc;
  logic [1:0] rr;
  int         lat_n;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_issue_ready", issue_ready, 1);
    chk("post_rst_result_valid", result_valid, 0);
    @(posedge clk); #1;

    // cadd with latency pinned
    do_issue(7'd0, 3'd0, 4'd3, acc, rr);
    chk("cadd_accept", acc, 1);
    chk("cadd_rr", rr, 2'b11);
    do_operands(32'h0002_0003, 32'h0005_0001, 2'b11);
    wait_result("cadd", 4'd3, 32'h0007_0004, lat_n);
    chk("cadd_latency", lat_n, LAT);

    // cconj reads rs1 only
    do_issue(7'd0, 3'd1, 4'd5, acc, rr);
    chk("cconj_rr", rr, 2'b01);
    do_operands(32'h0005_0003, 32'hDEAD_BEEF, 2'b01);
    wait_result("cconj", 4'd5, 32'hFFFB_0003, lat_n);

    do_issue(7'd0, 3'd3, 4'd6, acc, rr);
    do_operands(32'h0002_0001, 32'h0004_0003, 2'b11);
    wait_result("cmul", 4'd6, 32'h000A_FFFB, lat_n);

    do_issue(7'd0, 3'd2, 4'd7, acc, rr);
    do_operands(32'h0001_0001, 32'h0002_0002, 2'b11);
    wait_result("csub", 4'd7, 32'hFFFF_FFFF, lat_n);

    // rejects
    do_issue(7'd1, 3'd0, 4'd8, acc, rr);
    chk("rej_f7_accept", acc, 0);
    chk("rej_f7_rr", rr, 2'b00);
    do_issue(7'd0, 3'd4, 4'd9, acc, rr);
    chk("rej_f3_accept", acc, 0);
    chk("rej_f3_rr", rr, 2'b00);
    @(negedge clk);
    chk("rej_register_ready", register_ready, 0);
    chk("rej_issue_ready", issue_ready, 1);
    @(posedge clk); #1;

    // backpressure: fill all credits
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_issue(7'd0, 3'd0, i[ID_W-1:0], acc, rr);
      chk("bp_accept", acc, 1);
      do_operands(i, 32'h0010_0010, 2'b11);
    end
    @(negedge clk);
    chk("bp_full_issue_ready", issue_ready, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 result_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_id", result_id, 0);
    @(posedge clk); #1 result_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_pop_issue_ready", issue_ready, 1);
    @(posedge clk); #1;
    do_issue(7'd0, 3'd0, 4'd4, acc, rr);
    chk("bp_id4_accept", acc, 1);
    do_operands(32'd4, 32'h0010_0010, 2'b11);
    repeat (LAT + 1) @(posedge clk);
    #1 result_ready = 1'b1;
    for (int i = 1; i <= 4; i++)
      wait_result("drain", i[ID_W-1:0], 32'h0010_0010 + i, lat_n);

    repeat (4) @(negedge clk);
    chk("end_result_valid", result_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cvxif_cplx_copro.md
# cvxif_cplx_copro

Parametrised, pipelined complex-arithmetic coprocessor on the simplified CVXIF. It accepts custom-3 R-type instructions from the core and supports up to DEPTH instructions in flight. Each instruction carries an ID, is executed in a fixed-latency pipeline of LAT stages, and returns its result through an ID-tagged result FIFO that honours result backpressure. Each XLEN operand is one complex number: real part in bits [W-1:0], imaginary part in bits [XLEN-1:W], with W = XLEN/2.

## Interface
- XLEN, 32: register width; must be even.
- ID_W, 4: instruction ID width.
- DEPTH, 4: maximum outstanding instructions (pending operands + pipeline + result FIFO); power of two, ≥2.
- LAT, 2: execute pipeline stages, ≥1.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- issue_valid  in  1  core offers an instruction.
- issue_ready  out  1  coprocessor can take an issue handshake.
- issue_req_instr  in  32  instruction word.
- issue_req_id  in  ID_W  instruction ID.
- issue_resp_accept  out  1  instruction is ours; valid in the issue handshake cycle.
- issue_resp_writeback  out  1  accepted instruction writes rd.
- issue_resp_register_read  out  2  source registers required (bit0 = rs1, bit1 = rs2).
- register_valid  in  1  operands offered.
- register_ready  out  1  coprocessor can take operands.
- register_rs0, register_rs1  in  XLEN each  rs1 and rs2 values.
- register_rs_valid  in  2  per-operand valid.
- result_valid  out  1  result FIFO head is valid.
- result_ready  in  1  core takes the result.
- result_id  out  ID_W  ID of the head result.
- result_data  out  XLEN  head result value.

## Operation
- **Decode.** Match requires opcode [6:0] = 1111011, func7 [31:25] = 0000000, and func3 ∈ {000, 001, 010, 011}.
- **Operations**, with a = rs1 and b = rs2:
  - 000 cadd: (ar+br, ai+bi).
  - 001 cconj: (ar, −ai); reads rs1 only.
  - 010 csub: (ar−br, ai−bi).
  - 011 cmul: (ar·br − ai·bi, ar·bi + ai·br).
  - All arithmetic is two's complement, truncated modulo 2^W per half. No saturation, no flags.
- **Issue response.**
  - Matched instruction: accept = 1, writeback = 1, register_read = 01 for cconj, 11 otherwise.
  - Unmatched instruction: accept = 0, writeback = 0, register_read = 00. No credit is consumed and no state changes.
- **Credits.**
  - occ = pending-queue entries + valid pipeline stages + result-FIFO entries.
  - issue_ready = (occ < DEPTH), evaluated combinationally.
  - occ increments only on an accepted issue and decrements on a result handshake; a simultaneous accept and pop leaves occ unchanged.
  - Because issue is gated by credits, the pipeline never stalls and the FIFO never overflows.
- **Pending queue.**
  - Accepted {func3, id} is pushed into an in-order queue of DEPTH entries.
  - register_ready = queue non-empty.
  - Operand handshake condition: register_valid && register_ready && (register_rs_valid & mask) == mask, where mask is the head's register_read value.
  - On the handshake the head is popped and {op, id, rs0, rs1} enters pipeline stage 1. Operands always pair with the oldest pending instruction.
- **Pipeline.** LAT-stage valid/id/data shift register, with computation in stage 1. The last stage writes into the result FIFO (DEPTH entries, show-ahead).
- **Result side.** result_valid = FIFO non-empty; result_id and result_data are the FIFO head. The head pops on result_valid && result_ready.
- **Ordering.** Results return strictly in issue order.
- **Reset.** Asserting rst = 0 at any time, including mid-operation, clears all queues, the pipeline and the FIFO, and discards in-flight instructions.

## Timing
- Reset values: issue_ready = 0 while rst = 0, and 1 from the first cycle after release; issue_resp_* = 0; register_ready = 0; result_valid = 0; result_id = 0; result_data = 0.
- Issue response signals are combinational from issue_req_instr. The issue handshake completes in one cycle.
- register_ready rises at the earliest in the cycle after the accepting issue handshake.
- Operand handshake in cycle T gives result_valid in cycle T+LAT when the FIFO is empty and nothing older is pending.
- Back-to-back operand handshakes give one result per cycle with result_ready held at 1.
- Full: with occ = DEPTH, issue_ready = 0 until the cycle after a result pop. A pop in cycle T allows an accept in cycle T+1.
- Empty FIFO with simultaneous push and pop is not possible (show-ahead). A FIFO holding 1 entry with push and pop in the same cycle keeps 1 entry.

## Test plan
- **Reset.** Hold rst = 0 for 3 cycles, release → all outputs 0 during reset; issue_ready = 1 and result_valid = 0 afterwards.
- **cadd, LAT = 2.** cadd id 3, rs0 = 0x00020003, rs1 = 0x00050001 → accept = 1, register_read = 11; result 0x00070004 with result_id = 3 exactly 2 cycles after the operand handshake.
- **cconj.** cconj rs0 = 0x00050003 with register_rs_valid = 01 → handshake accepted; result 0xFFFB0003.
- **cmul.** cmul (1+2i)(3+4i): rs0 = 0x00020001, rs1 = 0x00040003 → 0x000AFFFB. csub 0x00010001 − 0x00020002 → 0xFFFFFFFF.
- **Reject.** func7 = 0000001 or func3 = 100 → accept = 0, register_read = 00, register_ready stays 0, occ unchanged.
- **Backpressure.** DEPTH = 4, result_ready = 0: issue IDs 0–3 → issue_ready drops after the 4th. Pulse result_ready once → ID 0 popped, issue_ready = 1 the next cycle, ID 4 accepted. Results drain in order 1, 2, 3, 4.
